mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single data port of the unified instruction/data memory between the CPU data path (`cpu` load/store) and a program loader/DMA port. It latches one request at a time and drives the memory's write-enable, read-enable, address and write-data lines. It returns read data and a one-cycle acknowledge to the winning requester. It sits between `cpu`/loader and `inst_mem`; the instruction-fetch port of `inst_mem` is untouched.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared inst_mem data port
//
// Purpose: latches one access at a time from requester 0 (CPU data) or
// requester 1 (loader/DMA), issues it to inst_mem for one cycle, then returns
// a one-cycle ack with read data.
// Optional feature macro: ARB_ROUND_ROBIN_EN (defined: round-robin tie
// break; undefined: requester 0 always wins a tie).
//
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_req0/1, i_we0/1                 request and write flag per requester
//   i_addr0/1, i_wdata0/1             word address and write data per requester
//   o_ack0/1, o_rdata0/1              completion pulse and read data per requester
//   o_mem_addr, o_mem_wdata           latched address/data to inst_mem
//   o_mem_write, o_mem_read           one-cycle memory strobes
//   i_mem_rdata                       registered read data from inst_mem
//   o_busy                            high whenever not idle
module mem_port_arbiter #(
   parameter int DATA_WIDTH        = 36,
   parameter int ADDRESS_BUS_WIDTH = 14
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_req0,
   input  logic                         i_req1,
   input  logic                         i_we0,
   input  logic                         i_we1,
   input  logic [ADDRESS_BUS_WIDTH-1:0] i_addr0,
   input  logic [ADDRESS_BUS_WIDTH-1:0] i_addr1,
   input  logic [DATA_WIDTH-1:0]        i_wdata0,
   input  logic [DATA_WIDTH-1:0]        i_wdata1,
   output logic                         o_ack0,
   output logic                         o_ack1,
   output logic [DATA_WIDTH-1:0]        o_rdata0,
   output logic [DATA_WIDTH-1:0]        o_rdata1,
   output logic [ADDRESS_BUS_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0]        o_mem_wdata,
   output logic                         o_mem_write,
   output logic                         o_mem_read,
   input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
   output logic                         o_busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   logic [1:0]                   state_q, state_d;
   logic                         grant_q, grant_d;
   logic                         we_q, we_d;
   logic [ADDRESS_BUS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
   logic                         win;

`ifdef ARB_ROUND_ROBIN_EN
   logic                         last_grant_q, last_grant_d;
`endif

   // Winner index for the current IDLE sample.
   always_comb begin
      win = 1'b0;
      if (i_req0 && i_req1) begin
`ifdef ARB_ROUND_ROBIN_EN
         // The requester that was not granted last takes the tie.
         win = ~last_grant_q;
`else
         win = 1'b0;
`endif
      end else begin
         // Single request (or none, where the value is unused).
         win = ~i_req0;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_req0 || i_req1) begin
               state_d = ST_ISSUE;
               grant_d = win;
               we_d    = win ? i_we1    : i_we0;
               addr_d  = win ? i_addr1  : i_addr0;
               wdata_d = win ? i_wdata1 : i_wdata0;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = win;
`endif
            end
         end
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         // Requester 0 wins the first tie after reset.
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // All outputs decode from registered state, so an async reset clears
   // them immediately, including a pending ack.
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_write = (state_q == ST_ISSUE) &&  we_q;
   assign o_mem_read  = (state_q == ST_ISSUE) && !we_q;
   assign o_ack0      = (state_q == ST_RESP) && !grant_q;
   assign o_ack1      = (state_q == ST_RESP) &&  grant_q;
   assign o_rdata0    = (o_ack0 && !we_q) ? i_mem_rdata : '0;
   assign o_rdata1    = (o_ack1 && !we_q) ? i_mem_rdata : '0;
   assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req0, i_req1, i_we0, i_we1;
   logic [13:0] i_addr0, i_addr1;
   logic [35:0] i_wdata0, i_wdata1;
   logic        o_ack0, o_ack1;
   logic [35:0] o_rdata0, o_rdata1;
   logic [13:0] o_mem_addr;
   logic [35:0] o_mem_wdata;
   logic        o_mem_write, o_mem_read;
   logic [35:0] i_mem_rdata;
   logic        o_busy;

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   mem_port_arbiter #(.DATA_WIDTH(36), .ADDRESS_BUS_WIDTH(14)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
      .i_addr0(i_addr0), .i_addr1(i_addr1),
      .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
      .o_ack0(o_ack0), .o_ack1(o_ack1),
      .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_mem_write(o_mem_write), .o_mem_read(o_mem_read),
      .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
   );

   // Memory environment: registered read, write at the strobe edge.
   logic [35:0] mem [0:63];
   always @(posedge i_clk) begin
      if (o_mem_write) mem[o_mem_addr[5:0]] <= o_mem_wdata;
      if (o_mem_read)  i_mem_rdata <= mem[o_mem_addr[5:0]];
   end

   // Reference model: transactions as edge numbers.
   logic [35:0] ref_mem [0:63];
   int          n;
   int          g_edge;
   int          next_ok;
   bit          last;
   bit          t_g, t_we;
   logic [13:0] t_addr;
   logic [35:0] t_wdata, t_rd;
   bit          done0, done1;
   int          ack_who[$];
   int          ack_at[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      g_edge  = -100;
      next_ok = 0;
      last    = 1'b1;
      t_g     = 1'b0;
      t_we    = 1'b0;
      t_addr  = '0;
      t_wdata = '0;
      t_rd    = '0;
   endtask

   task automatic cycle();
      bit win;
      bit strobe, ackc;
      @(posedge i_clk);
      n++;
      done0 = (g_edge == n - 2) && !t_g;
      done1 = (g_edge == n - 2) &&  t_g;
      if (i_rst) begin
         model_reset();
         done0 = 1'b0;
         done1 = 1'b0;
      end else if (n >= next_ok && (i_req0 || i_req1)) begin
         if (i_req0 && i_req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = !last;
`else
            win = 1'b0;
`endif
         end else begin
            win = !i_req0;
         end
         last    = win;
         g_edge  = n;
         next_ok = n + 3;
         t_g     = win;
         t_we    = win ? i_we1 : i_we0;
         t_addr  = win ? i_addr1 : i_addr0;
         t_wdata = win ? i_wdata1 : i_wdata0;
         if (t_we) ref_mem[t_addr[5:0]] = t_wdata;
         else      t_rd = ref_mem[t_addr[5:0]];
      end
      #1;
      strobe = (g_edge == n);
      ackc   = (g_edge == n - 1);
      chk("ack0",      64'(o_ack0),      64'(ackc && !t_g));
      chk("ack1",      64'(o_ack1),      64'(ackc &&  t_g));
      chk("rdata0",    64'(o_rdata0),    (ackc && !t_g && !t_we) ? 64'(t_rd) : 64'd0);
      chk("rdata1",    64'(o_rdata1),    (ackc &&  t_g && !t_we) ? 64'(t_rd) : 64'd0);
      chk("mem_write", 64'(o_mem_write), 64'(strobe &&  t_we));
      chk("mem_read",  64'(o_mem_read),  64'(strobe && !t_we));
      chk("mem_addr",  64'(o_mem_addr),  64'(t_addr));
      chk("mem_wdata", 64'(o_mem_wdata), 64'(t_wdata));
      chk("busy",      64'(o_busy),      64'(strobe || ackc));
      if (o_ack0) begin ack_who.push_back(0); ack_at.push_back(n); end
      if (o_ack1) begin ack_who.push_back(1); ack_at.push_back(n); end
   endtask

   // Requesters whose ack was sampled on the last edge drop their request.
   task automatic service();
      if (done0) i_req0 = 1'b0;
      if (done1) i_req1 = 1'b0;
   endtask

   initial begin
      bit [63:0]   r64;
      int          wr_cnt, busy_cnt, rd_cnt;
      logic [35:0] rd_cap;
      int          exp_who [4];

      for (int i = 0; i < 64; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      i_mem_rdata = '0;
      n = 0;
      model_reset();

      // A: reset with both requests high; first grant to requester 0.
      i_rst = 1'b1;
      i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 14'h0001; i_wdata0 = '0;
      i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 14'h0002; i_wdata1 = '0;
      repeat (3) cycle();
      i_rst = 1'b0;
      cycle();
      cycle();
      chk("first_grant_ack0", 64'(o_ack0), 64'd1);
      for (int i = 0; i < 12 && (i_req0 || i_req1); i++) begin
         cycle();
         service();
      end

      // B: loader write, then CPU read of the same word.
      i_req1 = 1'b1; i_we1 = 1'b1; i_addr1 = 14'h0010; i_wdata1 = 36'h123456789;
      wr_cnt = 0;
      for (int i = 0; i < 10 && i_req1; i++) begin
         cycle();
         if (o_mem_write) wr_cnt++;
         service();
      end
      chk("loader_write_strobes", 64'(wr_cnt), 64'd1);
      i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 14'h0010;
      rd_cap = '0;
      for (int i = 0; i < 10 && i_req0; i++) begin
         cycle();
         if (o_ack0) rd_cap = o_rdata0;
         service();
      end
      chk("cpu_read_data", 64'(rd_cap), 64'h123456789);

      // C: both held high for four accesses from a fresh reset.
      i_rst = 1'b1;
      #1;
      model_reset();
      cycle();
      i_rst = 1'b0;
      i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 14'h0001;
      i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 14'h0002;
      ack_who.delete();
      ack_at.delete();
      repeat (12) cycle();
      i_req0 = 1'b0;
      i_req1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_who = '{0, 1, 0, 1};
`else
      exp_who = '{0, 0, 0, 0};
`endif
      chk("tie_ack_count", 64'(ack_who.size()), 64'd4);
      for (int i = 0; i < 4 && i < ack_who.size(); i++) begin
         chk("tie_grant_order", 64'(ack_who[i]), 64'(exp_who[i]));
         if (i > 0) chk("tie_ack_spacing", 64'(ack_at[i] - ack_at[i-1]), 64'd3);
      end
      repeat (3) cycle();

      // D: address changed during ISSUE is not seen by memory.
      i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 14'h0004;
      cycle();
      i_addr0 = 14'h0005;
      #1;
      chk("latched_addr_issue", 64'(o_mem_addr), 64'h4);
      cycle();
      chk("latched_addr_resp", 64'(o_mem_addr), 64'h4);
      cycle();
      service();
      cycle();

      // E: reset during RESP of a read drops the ack immediately.
      i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 14'h0003;
      cycle();
      cycle();
      chk("pre_reset_ack0", 64'(o_ack0), 64'd1);
      i_rst = 1'b1;
      i_req0 = 1'b0;
      #1;
      chk("reset_ack0", 64'(o_ack0), 64'd0);
      chk("reset_busy", 64'(o_busy), 64'd0);
      chk("reset_rdata0", 64'(o_rdata0), 64'd0);
      chk("reset_addr", 64'(o_mem_addr), 64'd0);
      model_reset();
      cycle();
      i_rst = 1'b0;
      repeat (4) cycle();

      // F: single read, req dropped after ack: busy exactly two cycles.
      i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 14'h0010;
      busy_cnt = 0;
      rd_cnt   = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (o_busy) busy_cnt++;
         if (o_mem_read) rd_cnt++;
         service();
      end
      chk("single_busy_cycles", 64'(busy_cnt), 64'd2);
      chk("single_read_strobes", 64'(rd_cnt), 64'd1);

      // Random traffic under the request/hold protocol.
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (done0 || !i_req0) begin
            i_req0 = 1'($urandom_range(1, 0));
            i_we0  = 1'($urandom_range(1, 0));
            i_addr0 = 14'($urandom_range(15, 0));
            r64 = {$urandom(), $urandom()};
            i_wdata0 = r64[35:0];
         end
         if (done1 || !i_req1) begin
            i_req1 = 1'($urandom_range(1, 0));
            i_we1  = 1'($urandom_range(1, 0));
            i_addr1 = 14'($urandom_range(15, 0));
            r64 = {$urandom(), $urandom()};
            i_wdata1 = r64[35:0];
         end
      end
      i_req0 = 1'b0;
      i_req1 = 1'b0;
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
